// File: rtl/lightbike_pkg.sv
// lightbike_pkg: direction encodings, set-2 key codes and key-to-direction lookups shared by the lightbike blocks
package lightbike_pkg;
  typedef logic [1:0] dir_t;
  localparam dir_t UP    = 2'b00;
  localparam dir_t RIGHT = 2'b01;
  localparam dir_t DOWN  = 2'b10;
  localparam dir_t LEFT  = 2'b11;
  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} pfx_state_t;
  // {valid, dir}: player 1 steers with WASD
  function automatic logic [2:0] wasd_dir(input logic [7:0] c);
    return c == KEY_W ? {1'b1, UP} : c == KEY_S ? {1'b1, DOWN} :
           c == KEY_A ? {1'b1, LEFT} : c == KEY_D ? {1'b1, RIGHT} : 3'b000;
  endfunction
  // {valid, dir}: player 2 steers with the extended arrow keys
  function automatic logic [2:0] arrow_dir(input logic [7:0] c);
    return c == KEY_UP ? {1'b1, UP} : c == KEY_DOWN ? {1'b1, DOWN} :
           c == KEY_LEFT ? {1'b1, LEFT} : c == KEY_RIGHT ? {1'b1, RIGHT} : 3'b000;
  endfunction
endpackage

// File: rtl/dir_arbiter.sv
// dir_arbiter: one player's direction register with reversal rejection and one-turn-per-tick lock
module dir_arbiter
  import lightbike_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  dir_t req_dir,
  input  logic tick,
  input  logic init,
  input  dir_t default_dir,
  output dir_t dir
);
  dir_t dir_q, dir_d;
  logic lock_q, lock_d, lock_live, accept;
  always_comb begin
    lock_live = lock_q && !tick;
    accept = req_valid && !init && !lock_live && req_dir != dir_q && req_dir != (dir_q ^ 2'b10);
    dir_d = init ? default_dir : accept ? req_dir : dir_q;
    lock_d = !init && (accept || lock_live);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q <= default_dir;
      lock_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
      lock_q <= lock_d;
    end
  end
  assign dir = dir_q;
endmodule

// File: rtl/scancode_decoder.sv
// scancode_decoder: PS/2 set-2 prefix decoder turning key strokes into lightbike directions and start/reset pulses
module scancode_decoder
  import lightbike_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  input  logic       tick,
  input  logic       init,
  output dir_t       p1_dir,
  output dir_t       p2_dir,
  output logic       start_pulse,
  output logic       reset_req,
  output logic [7:0] last_code
);
  pfx_state_t state_q, state_d;
  logic space_held_q, start_q, rreq_q;
  logic [7:0] last_q;
  logic is_ext, is_brk, make_n, make_e, brk_n;
  logic [2:0] req1, req2;
  always_comb begin
    is_ext = scan_code == PFX_EXT;
    is_brk = scan_code == PFX_BRK;
    make_n = scan_valid && state_q == S_IDLE && !is_ext && !is_brk;
    make_e = scan_valid && state_q == S_EXT && !is_ext && !is_brk;
    brk_n = scan_valid && state_q == S_BRK;
    req1 = make_n ? wasd_dir(scan_code) : 3'b000;
    req2 = make_e ? arrow_dir(scan_code) : 3'b000;
    state_d = !scan_valid ? state_q :
              state_q == S_IDLE ? (is_ext ? S_EXT : is_brk ? S_BRK : S_IDLE) :
              state_q == S_EXT ? (is_brk ? S_EXT_BRK : is_ext ? S_EXT : S_IDLE) : S_IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      space_held_q <= 1'b0;
      start_q <= 1'b0;
      rreq_q <= 1'b0;
      last_q <= 8'h00;
    end else begin
      state_q <= state_d;
      start_q <= make_n && scan_code == KEY_SPACE && !space_held_q;
      rreq_q <= make_n && scan_code == KEY_ESC;
      // typematic repeats keep space_held set until the Space break arrives
      if (make_n && scan_code == KEY_SPACE) space_held_q <= 1'b1;
      else if (brk_n && scan_code == KEY_SPACE) space_held_q <= 1'b0;
      if (make_n || make_e) last_q <= scan_code;
    end
  end
  dir_arbiter u_p1 (
    .clk(clk), .reset(reset), .req_valid(req1[2]), .req_dir(req1[1:0]),
    .tick(tick), .init(init), .default_dir(RIGHT), .dir(p1_dir)
  );
  dir_arbiter u_p2 (
    .clk(clk), .reset(reset), .req_valid(req2[2]), .req_dir(req2[1:0]),
    .tick(tick), .init(init), .default_dir(LEFT), .dir(p2_dir)
  );
  assign start_pulse = start_q;
  assign reset_req = rreq_q;
  assign last_code = last_q;
endmodule
